// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Shared opcode, error-code and sequencer state encodings.
// Rev    : 1.0  initial release
// ============================================================================
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_DIV0    = 3'd1;
    localparam logic [2:0] ERR_OVF     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_ILLEGAL = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cu_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module : cu_timeout_timer
// Brief  : WAIT-cycle counter; expired flags the last allowed cycle.
// Rev    : 1.0  initial release
// ============================================================================
module cu_timeout_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int                c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == c_last);

endmodule
`default_nettype wire

// File: rtl/calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : calc_op_sequencer
// Brief  : Screens, issues and times out one calculator operation at a time.
// Rev    : 1.0  initial release
// ============================================================================
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cu_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              alu_start,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic [2:0]        rsp_err,
    output logic              busy
);

    state_t state;
    state_t state_nx;
    logic   done_seen;
    logic   expired;
    logic   illegal;
    logic   div0;

    assign illegal = (alu_op > OP_MOD);
    assign div0    = ((alu_op == OP_DIV) || (alu_op == OP_MOD)) && (alu_b == '0);

    // req_ready is gated by rst so nothing is offered while reset is held.
    assign req_ready = rst && cu_en && (state == ST_IDLE);
    assign alu_start = cu_en && (state == ST_ISSUE);
    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

    cu_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (cu_en && (state == ST_ISSUE)),
        .inc     (cu_en && (state == ST_WAIT)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (cu_en) begin
            case (state)
                ST_IDLE:  if (req_valid) state_nx = ST_CHECK;
                ST_CHECK: state_nx = (illegal || div0) ? ST_RESP : ST_ISSUE;
                ST_ISSUE: state_nx = ST_WAIT;
                ST_WAIT:  if (alu_done || done_seen || expired) state_nx = ST_RESP;
                ST_RESP:  if (rsp_ready) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_err    <= ERR_OK;
            done_seen  <= 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                alu_op <= req_op;
                alu_a  <= req_a;
                alu_b  <= req_b;
            end
            if (cu_en) begin
                if (state == ST_CHECK) begin
                    if (illegal) begin
                        rsp_result <= '0;
                        rsp_err    <= ERR_ILLEGAL;
                    end else if (div0) begin
                        rsp_result <= '0;
                        rsp_err    <= ERR_DIV0;
                    end
                end
                if (state == ST_WAIT) begin
                    // A completion latched during a stall is the first one; keep it.
                    if (!done_seen) begin
                        if (alu_done) begin
                            rsp_result <= alu_result;
                            rsp_err    <= alu_ovf ? ERR_OVF : ERR_OK;
                        end else if (expired) begin
                            rsp_result <= '0;
                            rsp_err    <= ERR_TIMEOUT;
                        end
                    end
                    done_seen <= 1'b0;
                end
            end else if ((state == ST_WAIT) && alu_done) begin
                rsp_result <= alu_result;
                rsp_err    <= alu_ovf ? ERR_OVF : ERR_OK;
                done_seen  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_op_sequencer
// Brief  : Directed scoreboard bench for calc_op_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
module tb_calc_op_sequencer;
    import calc_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cu_en;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       alu_start;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_ovf;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic [2:0] rsp_err;
    logic       busy;

    typedef struct {
        logic [7:0] res;
        logic [2:0] err;
        int         lat;
        int         hs;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   starts = 0;
    int   last_hs = 0;

    calc_op_sequencer #(
        .DATA_W  (8),
        .TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cu_en      (cu_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (alu_start) starts <= starts + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [2:0] ee, input int lat, input bit push);
        exp_t e;
        bit   rdy = 1'b0;
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin rdy = 1'b1; break; end
            @(negedge clk);
        end
        chk("req_ready", 32'(rdy), 32'd1);
        e.res = er; e.err = ee; e.lat = lat; e.hs = cyc;
        if (push) q.push_back(e);
        last_hs = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic run_alu(input int d, input logic [7:0] res, input logic ovf);
        bit st = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (alu_start) begin st = 1'b1; break; end
            @(negedge clk);
        end
        chk("alu_start_seen", 32'(st), 32'd1);
        repeat (d) @(negedge clk);
        alu_result = res; alu_ovf = ovf; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0; alu_result = 8'h00; alu_ovf = 1'b0;
    endtask

    task automatic get_rsp(input int hold, output int rh);
        exp_t e;
        bit   seen = 1'b0;
        rh = 0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        chk("rsp_seen", 32'(seen), 32'd1);
        chk("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (seen && q.size() > 0) begin
            e = q.pop_front();
            chk("latency", 32'(cyc - e.hs), 32'(e.lat));
            chk("rsp_result", 32'(rsp_result), 32'(e.res));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            for (int i = 0; i < hold; i++) begin
                rsp_ready = 1'b0;
                @(negedge clk);
                chk("hold_valid", 32'(rsp_valid), 32'd1);
                chk("hold_result", 32'(rsp_result), 32'(e.res));
                chk("hold_err", 32'(rsp_err), 32'(e.err));
            end
            rsp_ready = 1'b1;
            rh = cyc;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("rsp_released", 32'(rsp_valid), 32'd0);
        end
    endtask

    initial begin
        int s0;
        int rh;
        rst = 1'b0; cu_en = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 8'd0; req_b = 8'd0;
        alu_done = 1'b0; alu_result = 8'd0; alu_ovf = 1'b0; rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Disabled sequencer refuses requests; stray done in IDLE ignored
        cu_en = 1'b0; req_valid = 1'b1; alu_done = 1'b1;
        @(negedge clk);
        chk("stall_ready", 32'(req_ready), 32'd0);
        alu_done = 1'b0;
        @(negedge clk);
        chk("stall_idle", 32'(busy), 32'd0);
        req_valid = 1'b0; cu_en = 1'b1;
        @(negedge clk);

        // ADD 20+22
        s0 = starts;
        send(OP_ADD, 8'd20, 8'd22, 8'd42, ERR_OK, 4, 1'b1);
        chk("check_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("add_start", 32'(alu_start), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'(OP_ADD));
        chk("add_alu_a", 32'(alu_a), 32'd20);
        chk("add_alu_b", 32'(alu_b), 32'd22);
        @(negedge clk);
        chk("add_start_pulse", 32'(alu_start), 32'd0);
        alu_result = 8'd42; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0; alu_result = 8'd0;
        get_rsp(0, rh);
        chk("add_one_start", 32'(starts - s0), 32'd1);

        // DIV by zero screened
        s0 = starts;
        send(OP_DIV, 8'd9, 8'd0, 8'd0, ERR_DIV0, 2, 1'b1);
        get_rsp(0, rh);
        chk("div0_no_start", 32'(starts - s0), 32'd0);

        // Illegal op, then back-to-back MUL
        s0 = starts;
        send(3'd6, 8'd1, 8'd1, 8'd0, ERR_ILLEGAL, 2, 1'b1);
        get_rsp(0, rh);
        chk("illegal_no_start", 32'(starts - s0), 32'd0);
        send(OP_MUL, 8'd3, 8'd4, 8'd12, ERR_OK, 4, 1'b1);
        chk("b2b_accept", 32'(last_hs), 32'(rh + 1));
        run_alu(1, 8'd12, 1'b0);
        get_rsp(0, rh);

        // Timeout after exactly 15 WAIT cycles, and done on the last one
        send(OP_MUL, 8'd5, 8'd6, 8'd0, ERR_TIMEOUT, 18, 1'b1);
        get_rsp(0, rh);
        send(OP_MUL, 8'd7, 8'd7, 8'd49, ERR_OK, 18, 1'b1);
        run_alu(15, 8'd49, 1'b0);
        get_rsp(0, rh);

        // Stall during WAIT with done arriving while stalled
        send(OP_ADD, 8'h40, 8'h3F, 8'h7F, ERR_OVF, 9, 1'b1);
        @(negedge clk);
        @(negedge clk);
        cu_en = 1'b0;
        @(negedge clk);
        alu_result = 8'h7F; alu_ovf = 1'b1; alu_done = 1'b1;
        @(negedge clk);
        alu_result = 8'h00; alu_ovf = 1'b0; alu_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stall_no_rsp", 32'(rsp_valid), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        @(negedge clk);
        cu_en = 1'b1;
        get_rsp(3, rh);

        // Reset in WAIT aborts without a response
        send(OP_ADD, 8'd1, 8'd2, 8'd3, ERR_OK, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("arst_alu_start", 32'(alu_start), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_alu_a", 32'(alu_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_rsp", 32'(rsp_valid), 32'd0);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
- Control-unit sequencer for the Pocket_Calculator_Processor.
- Accepts one calculator operation at a time from the keypad/decode side over a valid/ready handshake.
- Screens illegal opcodes and divide-by-zero, then issues the operation to the multi-cycle ALU and waits for completion under a timeout.
- Returns result plus error code over a second valid/ready handshake; all progress is gated by the control-unit enable produced by the enable flop.

Parameters:
- DATA_W, 8: operand/result width in bits.
- TIMEOUT, 15: maximum WAIT cycles allowed for alu_done before the sequencer aborts; legal range 2..255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset; low forces every register to its reset value immediately.
- cu_en  input  1  control-unit enable from the enable flop; low stalls the sequencer.
- req_valid  input  1  request offered.
- req_ready  output  1  sequencer can accept; equals (state==IDLE) && cu_en.
- req_op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5-7 illegal.
- req_a  input  DATA_W  operand A.
- req_b  input  DATA_W  operand B.
- alu_start  output  1  one-cycle ALU launch pulse.
- alu_op  output  3  registered opcode to the ALU.
- alu_a  output  DATA_W  registered operand A.
- alu_b  output  DATA_W  registered operand B.
- alu_done  input  1  ALU completion pulse.
- alu_result  input  DATA_W  ALU result; valid with alu_done.
- alu_ovf  input  1  ALU overflow flag; valid with alu_done.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts the response.
- rsp_result  output  DATA_W  result; 0 on any error other than OVF.
- rsp_err  output  3  0 OK, 1 DIV0, 2 OVF, 3 TIMEOUT, 4 ILLEGAL.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE; alu_op, alu_a, alu_b, rsp_result, rsp_err, timer and done_seen all 0; outputs req_ready=0 while rst is low, alu_start=0, rsp_valid=0, busy=0.
- States: IDLE, CHECK, ISSUE, WAIT, RESP. Only registered state drives outputs; alu_start = (state==ISSUE) && cu_en; rsp_valid = (state==RESP).
- IDLE: on req_valid && req_ready, capture op/a/b, go to CHECK.
- CHECK: op greater than 4 goes to RESP with err=4, result=0. Op 3 or 4 with b==0 goes to RESP with err=1, result=0; the ALU is never started. Otherwise go to ISSUE.
- ISSUE: alu_start high for exactly one cycle, then go to WAIT; timer cleared to 0.
- WAIT: timer increments each enabled cycle.
  - alu_done (or done_seen) goes to RESP with result=alu_result and err = alu_ovf ? 2 : 0. rsp_result carries the wrapped value on OVF.
  - If timer==TIMEOUT-1 with no done, go to RESP with err=3, result=0.
  - alu_done and timeout in the same cycle: done wins.
- RESP: hold rsp_valid and data stable until rsp_valid && rsp_ready && cu_en, then go to IDLE. No retraction.
- Latency: handshake in cycle T gives CHECK at T+1, alu_start at T+2 and WAIT at T+3. alu_done at T+3 gives rsp_valid at T+4. Screened errors give rsp_valid at T+2.
- cu_en low freezes state and timer, and forces req_ready=0 and alu_start=0. An alu_done arriving while stalled in WAIT sets done_seen and latches alu_result/alu_ovf; it is consumed on the next enabled cycle. done_seen clears on leaving WAIT.
- Stray alu_done outside WAIT is ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. No response is produced for the aborted request.
- Back-to-back operation: a new request can be accepted in the cycle after the RESP handshake (IDLE).

Decomposition:
- Shared package calc_pkg holds:
  - opcode constants OP_ADD..OP_MOD;
  - error constants ERR_OK, ERR_DIV0, ERR_OVF, ERR_TIMEOUT, ERR_ILLEGAL;
  - the state encoding for the five states.
- One sub-module, cu_timeout_timer, is natural. Ports: clk, rst, clr, inc, expired. Width is $clog2(TIMEOUT); expired = (count==TIMEOUT-1).

Test Plan:
- ADD a=8'd20, b=8'd22, alu_done 1 cycle after alu_start with result 42 -> rsp_valid at T+4, rsp_result=42, rsp_err=0, alu_start exactly one pulse.
- DIV a=8'd9, b=0 -> no alu_start, rsp_valid at T+2, rsp_err=1, rsp_result=0.
- req_op=3'd6 -> rsp_err=4 at T+2, ALU untouched; then MUL 3*4 is accepted the cycle after the response handshake -> result 12.
- MUL with alu_done never asserted, TIMEOUT=15 -> exactly 15 WAIT cycles, then rsp_err=3. Separately, done on the final WAIT cycle -> rsp_err=0.
- cu_en dropped for 5 cycles during WAIT with alu_done (result 8'h7F, ovf=1) pulsed during the stall -> on re-enable, rsp_result=8'h7F, rsp_err=2. With rsp_ready low for 3 cycles the response stays stable.
- rst pulled low while in WAIT -> busy=0, rsp_valid=0, alu_start=0 immediately. After release, req_ready=1 with cu_en high.
